// File: rtl/sha256_round_engine.sv
// ---------------------------------------------------------------------------
// sha256_round_engine
//
// Iterative SHA-256 compression engine. It accepts one 512-bit message block
// plus a chaining state (or the standard IV), runs the 64 FIPS 180-4 rounds
// at RPC rounds per clock, and returns the updated 256-bit state together
// with an opaque tag that travels with the block.
//
// Parameters
//   RPC    rounds evaluated per clock (1, 2, 4, 8 or 16)
//   TAG_W  width of the per-block tag
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   blk_vld    input block valid
//   blk_rdy    input block ready
//   blk_words  message block, [511:480] = W[0] ... [31:0] = W[15]
//   blk_first  1: start from the SHA-256 IV, 0: start from blk_state
//   blk_state  chaining state, [255:224] = H0 ... [31:0] = H7
//   blk_tag    opaque tag for this block
//   dig_vld    result valid
//   dig_rdy    result ready
//   dig_state  updated state, same packing as blk_state
//   dig_tag    tag of the block that produced dig_state
//   busy       engine is running or holding a result
// ---------------------------------------------------------------------------
module sha256_round_engine #(
  parameter int RPC   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_vld,
  output logic             blk_rdy,
  input  logic [511:0]     blk_words,
  input  logic             blk_first,
  input  logic [255:0]     blk_state,
  input  logic [TAG_W-1:0] blk_tag,
  output logic             dig_vld,
  input  logic             dig_rdy,
  output logic [255:0]     dig_state,
  output logic [TAG_W-1:0] dig_tag,
  output logic             busy
);

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
      $error("sha256_round_engine: RPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam int DATA_W = 32;

  // Round counter holds the index of the first round of the current cycle;
  // the final RUN cycle starts at round 64-RPC.
  localparam logic [5:0] STEP   = 6'(RPC);
  localparam logic [5:0] LAST_T = 6'(64 - RPC);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [DATA_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // FIPS 180-4 logical functions
  function automatic logic [DATA_W-1:0] big_sigma0(input logic [DATA_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [DATA_W-1:0] big_sigma1(input logic [DATA_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [DATA_W-1:0] small_sigma0(input logic [DATA_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] small_sigma1(input logic [DATA_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [DATA_W-1:0] ch(input logic [DATA_W-1:0] e,
                                           input logic [DATA_W-1:0] f,
                                           input logic [DATA_W-1:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [DATA_W-1:0] maj(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [5:0]               cnt_q;
  logic [15:0][DATA_W-1:0]  w_q;      // schedule window, index 0 = W[t]
  logic [7:0][DATA_W-1:0]   wk_q;     // working variables, index 0 = a
  logic [7:0][DATA_W-1:0]   h_q;      // state the block started from
  logic [TAG_W-1:0]         tag_q;
  logic [255:0]             dig_state_q;
  logic [TAG_W-1:0]         dig_tag_q;

  logic                     accept;
  logic                     last_run;
  logic [15:0][DATA_W-1:0]  load_w;
  logic [7:0][DATA_W-1:0]   init_h;
  logic [15:0][DATA_W-1:0]  win_n;
  logic [7:0][DATA_W-1:0]   wk_n;
  logic [DATA_W-1:0]        t1, t2, w_new;
  logic [255:0]             dig_d;

  // Handshake and status
  assign blk_rdy   = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & dig_rdy));
  assign accept    = blk_vld & blk_rdy;
  assign last_run  = (state_q == S_RUN) && (cnt_q == LAST_T);
  assign dig_vld   = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dig_state = dig_state_q;
  assign dig_tag   = dig_tag_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (blk_vld) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_T) state_d = S_DONE;
      S_DONE:  if (dig_rdy) state_d = blk_vld ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Unpack the bus-order block and chaining state into word arrays
  always_comb begin
    load_w = '0;
    init_h = '0;
    for (int i = 0; i < 16; i++) begin
      load_w[i] = blk_words[DATA_W*(15-i) +: DATA_W];
    end
    for (int i = 0; i < 8; i++) begin
      init_h[i] = blk_first ? IV[DATA_W*(7-i) +: DATA_W]
                            : blk_state[DATA_W*(7-i) +: DATA_W];
    end
  end

  // RPC chained rounds. Each round consumes W[t] from the head of the window
  // and appends W[t+16]; words produced past round 63 are never consumed.
  always_comb begin
    wk_n  = wk_q;
    win_n = w_q;
    t1    = '0;
    t2    = '0;
    w_new = '0;
    for (int r = 0; r < RPC; r++) begin
      t1 = wk_n[7] + big_sigma1(wk_n[4]) + ch(wk_n[4], wk_n[5], wk_n[6])
         + K[cnt_q + 6'(r)] + win_n[0];
      t2 = big_sigma0(wk_n[0]) + maj(wk_n[0], wk_n[1], wk_n[2]);
      w_new = small_sigma1(win_n[14]) + win_n[9] + small_sigma0(win_n[1]) + win_n[0];
      for (int j = 7; j > 0; j--) begin
        wk_n[j] = wk_n[j-1];
      end
      wk_n[4] = wk_n[4] + t1;
      wk_n[0] = t1 + t2;
      for (int j = 0; j < 15; j++) begin
        win_n[j] = win_n[j+1];
      end
      win_n[15] = w_new;
    end
  end

  // Feed-forward of the block's starting state into the final working set
  always_comb begin
    dig_d = '0;
    for (int i = 0; i < 8; i++) begin
      dig_d[DATA_W*(7-i) +: DATA_W] = h_q[i] + wk_n[i];
    end
  end

  // Control registers and result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dig_state_q <= '0;
      dig_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + STEP;
      end
      if (last_run) begin
        dig_state_q <= dig_d;
        dig_tag_q   <= tag_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (accept) begin
      w_q   <= load_w;
      wk_q  <= init_h;
      h_q   <= init_h;
      tag_q <= blk_tag;
    end else if (state_q == S_RUN) begin
      w_q  <= win_n;
      wk_q <= wk_n;
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // index 0: RPC=1 instance, index 1: RPC=4 instance
  logic         rst_n     [2];
  logic         blk_vld   [2];
  logic         blk_rdy   [2];
  logic [511:0] blk_words [2];
  logic         blk_first [2];
  logic [255:0] blk_state [2];
  logic [3:0]   blk_tag   [2];
  logic         dig_vld   [2];
  logic         dig_rdy   [2];
  logic [255:0] dig_state [2];
  logic [3:0]   dig_tag   [2];
  logic         busy      [2];

  sha256_round_engine #(.RPC(1), .TAG_W(4)) u_rpc1 (
    .clk(clk), .rst_n(rst_n[0]), .blk_vld(blk_vld[0]), .blk_rdy(blk_rdy[0]),
    .blk_words(blk_words[0]), .blk_first(blk_first[0]), .blk_state(blk_state[0]),
    .blk_tag(blk_tag[0]), .dig_vld(dig_vld[0]), .dig_rdy(dig_rdy[0]),
    .dig_state(dig_state[0]), .dig_tag(dig_tag[0]), .busy(busy[0])
  );

  sha256_round_engine #(.RPC(4), .TAG_W(4)) u_rpc4 (
    .clk(clk), .rst_n(rst_n[1]), .blk_vld(blk_vld[1]), .blk_rdy(blk_rdy[1]),
    .blk_words(blk_words[1]), .blk_first(blk_first[1]), .blk_state(blk_state[1]),
    .blk_tag(blk_tag[1]), .dig_vld(dig_vld[1]), .dig_rdy(dig_rdy[1]),
    .dig_state(dig_state[1]), .dig_tag(dig_tag[1]), .busy(busy[1])
  );

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_ref(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] h [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) begin
      h[i] = hin[255-32*i -: 32];
      v[i] = h[i];
    end
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand_st();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int exp_lat(input int d);
    return (d == 0) ? 65 : 17;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_accept(input int d, input logic [511:0] w, input logic first,
                           input logic [255:0] st, input logic [3:0] tag, output int waited);
    blk_words[d] = w;
    blk_first[d] = first;
    blk_state[d] = st;
    blk_tag[d]   = tag;
    blk_vld[d]   = 1'b1;
    waited = 0;
    #1;
    while (blk_rdy[d] !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (blk_rdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout d=%0d blk_rdy=%b expected 1", d, blk_rdy[d]);
    end
    @(posedge clk); #1;
    blk_vld[d] = 1'b0;
  endtask

  task automatic wait_dig(input int d, input bit noise, output int lat);
    lat = 1;
    while (dig_vld[d] !== 1'b1 && lat < 200) begin
      if (noise) begin
        blk_vld[d]   = 1'($urandom_range(0, 1));
        blk_words[d] = rand_blk();
        blk_tag[d]   = 4'($urandom);
        blk_first[d] = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    blk_vld[d] = 1'b0;
  endtask

  task automatic pop(input int d);
    dig_rdy[d] = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      blk_vld[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (blk_rdy[d] !== 1'b0) begin errors++; $display("FAIL rst_blk_rdy_low d=%0d got %b expected 0", d, blk_rdy[d]); end
      checks++;
      if (dig_vld[d] !== 1'b0 || busy[d] !== 1'b0) begin
        errors++; $display("FAIL rst_vld_busy d=%0d got %b%b expected 00", d, dig_vld[d], busy[d]);
      end
      checks++;
      if (dig_state[d] !== 256'h0 || dig_tag[d] !== 4'h0) begin
        errors++; $display("FAIL rst_dig_clear d=%0d got %h/%h expected 0/0", d, dig_state[d], dig_tag[d]);
      end
      blk_vld[d] = 1'b0;
      rst_n[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (blk_rdy[d] !== 1'b1) begin errors++; $display("FAIL rst_release_rdy d=%0d got %b expected 1", d, blk_rdy[d]); end
    end
  endtask

  task automatic check_result(input string name, input int d, input int lat, input int elat,
                              input logic [255:0] edig, input logic [3:0] etag);
    checks++;
    if (lat !== elat) begin errors++; $display("FAIL %s_latency d=%0d got %0d expected %0d", name, d, lat, elat); end
    checks++;
    if (dig_state[d] !== edig) begin errors++; $display("FAIL %s_digest d=%0d got %h expected %h", name, d, dig_state[d], edig); end
    checks++;
    if (dig_tag[d] !== etag) begin errors++; $display("FAIL %s_tag d=%0d got %h expected %h", name, d, dig_tag[d], etag); end
  endtask

  task automatic test_vectors();
    logic [511:0] abc, empty, b1, b2;
    logic [255:0] mid;
    int waited, lat;
    abc   = {32'h61626380, 448'h0, 32'h00000018};
    empty = {32'h80000000, 480'h0};
    b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    b2 = {480'h0, 32'h000001c0};

    do_accept(0, abc, 1'b1, rand_st(), 4'd3, waited);
    wait_dig(0, 1'b0, lat);
    check_result("abc", 0, lat, 65,
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 4'd3);
    pop(0);

    do_accept(1, empty, 1'b1, rand_st(), 4'd9, waited);
    wait_dig(1, 1'b0, lat);
    check_result("empty", 1, lat, 17,
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 4'd9);
    pop(1);

    mid = sha_ref(IV, b1);
    for (int d = 0; d < 2; d++) begin
      do_accept(d, b1, 1'b1, 256'h0, 4'd5, waited);
      wait_dig(d, 1'b0, lat);
      check_result("two_blk1", d, lat, exp_lat(d), mid, 4'd5);
      pop(d);
      do_accept(d, b2, 1'b0, mid, 4'd6, waited);
      wait_dig(d, 1'b0, lat);
      check_result("two_blk2", d, lat, exp_lat(d),
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 4'd6);
      pop(d);
    end
  endtask

  task automatic test_random();
    logic [511:0] w;
    logic [255:0] st, edig;
    logic first;
    logic [3:0] tag;
    int waited, lat, hold;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 10; n++) begin
        w = rand_blk(); st = rand_st(); first = 1'($urandom); tag = 4'($urandom);
        edig = sha_ref(first ? IV : st, w);
        do_accept(d, w, first, st, tag, waited);
        wait_dig(d, 1'b1, lat);
        check_result("random", d, lat, exp_lat(d), edig, tag);
        hold = $urandom_range(0, 3);
        if (hold > 0) begin
          dig_rdy[d] = 1'b0;
          repeat (hold) begin @(posedge clk); #1; end
          checks++;
          if (dig_vld[d] !== 1'b1 || dig_state[d] !== edig) begin
            errors++; $display("FAIL random_hold d=%0d got vld=%b %h expected 1 %h", d, dig_vld[d], dig_state[d], edig);
          end
        end
        pop(d);
        checks++;
        if (dig_vld[d] !== 1'b0 || busy[d] !== 1'b0) begin
          errors++; $display("FAIL random_pop_idle d=%0d got vld=%b busy=%b expected 0 0", d, dig_vld[d], busy[d]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] w;
    logic [255:0] edig;
    logic [3:0] tag;
    int waited, lat, bad;
    w = rand_blk(); tag = 4'($urandom);
    edig = sha_ref(IV, w);
    dig_rdy[1] = 1'b0;
    do_accept(1, w, 1'b1, 256'h0, tag, waited);
    wait_dig(1, 1'b0, lat);
    check_result("bp", 1, lat, 17, edig, tag);
    blk_vld[1] = 1'b1; blk_words[1] = rand_blk(); blk_first[1] = 1'b1; blk_tag[1] = ~tag;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (dig_vld[1] !== 1'b1 || dig_state[1] !== edig || dig_tag[1] !== tag || blk_rdy[1] !== 1'b0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b %h/%h expected 1 0 %h/%h",
                              c, dig_vld[1], blk_rdy[1], dig_state[1], dig_tag[1], edig, tag);
      end
    end
    blk_vld[1] = 1'b0;
    pop(1);
    checks++;
    if (busy[1] !== 1'b0 || dig_vld[1] !== 1'b0) begin
      errors++; $display("FAIL bp_release d=1 got busy=%b vld=%b expected 0 0", busy[1], dig_vld[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] wa, wb;
    logic [255:0] sa, ea, eb;
    logic [3:0] ta, tb;
    int waited, lat;
    for (int d = 0; d < 2; d++) begin
      wa = rand_blk(); wb = rand_blk(); sa = rand_st();
      ta = 4'($urandom); tb = 4'($urandom);
      ea = sha_ref(sa, wa); eb = sha_ref(IV, wb);
      do_accept(d, wa, 1'b0, sa, ta, waited);
      wait_dig(d, 1'b0, lat);
      check_result("b2b_a", d, lat, exp_lat(d), ea, ta);
      do_accept(d, wb, 1'b1, rand_st(), tb, waited);
      checks++;
      if (waited !== 0) begin errors++; $display("FAIL b2b_zero_bubble d=%0d got wait=%0d expected 0", d, waited); end
      checks++;
      if (busy[d] !== 1'b1 || dig_vld[d] !== 1'b0) begin
        errors++; $display("FAIL b2b_run d=%0d got busy=%b vld=%b expected 1 0", d, busy[d], dig_vld[d]);
      end
      wait_dig(d, 1'b0, lat);
      check_result("b2b_b", d, lat, exp_lat(d), eb, tb);
      pop(d);
    end
  endtask

  task automatic test_reset_midrun();
    logic [511:0] w;
    logic [255:0] edig;
    int waited, lat, seen;
    do_accept(0, rand_blk(), 1'b1, 256'h0, 4'hA, waited);
    repeat (30) begin @(posedge clk); #1; end
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dig_vld[0] !== 1'b0 || busy[0] !== 1'b0 || blk_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got vld=%b busy=%b rdy=%b expected 0 0 0", dig_vld[0], busy[0], blk_rdy[0]);
    end
    rst_n[0] = 1'b1;
    #1;
    checks++;
    if (blk_rdy[0] !== 1'b1) begin errors++; $display("FAIL midrun_release_rdy got %b expected 1", blk_rdy[0]); end
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (dig_vld[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrun_stale got %0d valid cycles expected 0", seen); end
    w = rand_blk();
    edig = sha_ref(IV, w);
    do_accept(0, w, 1'b1, 256'h0, 4'h7, waited);
    wait_dig(0, 1'b0, lat);
    check_result("post_reset", 0, lat, 65, edig, 4'h7);
    pop(0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; blk_vld[d] = 1'b0; blk_words[d] = '0; blk_first[d] = 1'b0;
      blk_state[d] = '0; blk_tag[d] = '0; dig_rdy[d] = 1'b1;
    end
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
